// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter serving the icache and dcache.
// The dcache has strict priority. Each grant lasts until the RAM reports
// ACCESS or ERROR, the wait counter reaches TIMEOUT-1, or the requester
// withdraws. Every grant returns to IDLE, so one word costs one grant plus
// one arbitration cycle. State, wait counter and sticky error flag are
// registered; all other outputs are decoded combinationally from the state
// and the live inputs.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DGNT = 2'd1,
      IGNT = 2'd2
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   // Last cycle a grant may wait; the access is released on this count.
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   logic       d_req_s;
   logic       ram_done_s;
   logic       ram_fail_s;
   logic       ack_s;

   // Request and termination conditions shared by both grant states.
   always_comb begin
      d_req_s    = dREN | dWEN;
      ram_done_s = (ramstate == RAM_ACCESS);
      ram_fail_s = (ramstate == RAM_ERROR) | (cnt_q == CNT_LAST);
      ack_s      = ram_done_s | ram_fail_s;
   end

   // Next-state, wait-counter, error flag and output decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      iload    = 32'd0;
      dload    = 32'd0;
      iwait    = 1'b1;
      dwait    = 1'b1;

      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (d_req_s) begin
               state_d = DGNT;
            end else if (iREN) begin
               state_d = IGNT;
            end else begin
               state_d = IDLE;
            end
         end

         DGNT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            dload    = ramload;
            if (ack_s) begin
               // Completion wins over withdrawal; only a non-ACCESS
               // release counts as an error.
               dwait   = 1'b0;
               state_d = IDLE;
               cnt_d   = 8'd0;
               if (!ram_done_s) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end else if (!d_req_s) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         IGNT: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            iload   = ramload;
            if (ack_s) begin
               iwait   = 1'b0;
               state_d = IDLE;
               cnt_d   = 8'd0;
               if (!ram_done_s) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end else if (!iREN) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State, counter and sticky error registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign err = err_q;

endmodule
